// File: rtl/exp3_fluxo_dados_pkg.sv
// Shared constants for the Experiment 3 memory-check datapath.
package exp3_fluxo_dados_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ROM_DEPTH  = 16;

  // Last counter value for the default address width.
  localparam int unsigned FIM_CONTAGEM = (1 << ADDR_W_DEF) - 1;

  typedef logic [3:0] rom_word_t;

  // Reference sequence the player must reproduce, addresses 0..15.
  localparam rom_word_t ROM_INIT [ROM_DEPTH] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };

  // Terminal count for an arbitrary counter width.
  function automatic logic [31:0] fim_contagem(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/exp3_rom_16x4.sv
// Combinational read-only reference memory, contents from the package.
module exp3_rom_16x4
  import exp3_fluxo_dados_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] dado
);

  logic [3:0] idx;

  // Zero-latency lookup; the table has 16 entries regardless of ADDR_W.
  always_comb begin
    idx  = 4'(endereco);
    dado = DATA_W'(ROM_INIT[idx]);
  end

endmodule

// File: rtl/exp3_fluxo_dados.sv
// Datapath: address counter, reference ROM, switch register, comparator,
// switch synchronizer and play-made pulse detector.
module exp3_fluxo_dados
  import exp3_fluxo_dados_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic [DATA_W-1:0] chaves,
  output logic              fimC,
  output logic              igual,
  output logic              jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_chaves
);

  localparam logic [ADDR_W-1:0] FIM_LOCAL = ADDR_W'(fim_contagem(ADDR_W));

  logic [ADDR_W-1:0] contagem_q, contagem_d;
  logic [DATA_W-1:0] registro_q, registro_d;
  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] s2_dly_q, s2_dly_d;
  logic [DATA_W-1:0] memoria;

  exp3_rom_16x4 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .endereco(contagem_q),
    .dado    (memoria)
  );

  // Address counter next value: clear wins over increment, wraps naturally.
  always_comb begin
    contagem_d = contagem_q;
    if (zeraC)
      contagem_d = '0;
    else if (contaC)
      contagem_d = contagem_q + ADDR_W'(1);
  end

  // Switch register next value: loads the synchronized switches only.
  always_comb begin
    registro_d = registro_q;
    if (zeraR)
      registro_d = '0;
    else if (registraR)
      registro_d = s2_q;
  end

  // Synchronizer chain plus one extra stage for edge detection.
  always_comb begin
    s1_d     = chaves;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
  end

  // State registers; reset also flushes in-flight synchronizer data.
  always_ff @(posedge clock) begin
    if (reset) begin
      contagem_q <= '0;
      registro_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s2_dly_q   <= '0;
    end else begin
      contagem_q <= contagem_d;
      registro_q <= registro_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s2_dly_q   <= s2_dly_d;
    end
  end

  // Outputs: comparator, terminal count and zero-to-nonzero play pulse.
  always_comb begin
    db_contagem = contagem_q;
    db_memoria  = memoria;
    db_chaves   = registro_q;
    fimC        = (contagem_q == FIM_LOCAL);
    igual       = (registro_q == memoria);
    jogada      = (s2_q != '0) && (s2_dly_q == '0);
  end

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Self-checking bench for exp3_fluxo_dados.
module tb_exp3_fluxo_dados;

  logic       clock = 1'b0;
  logic       reset, zeraC, contaC, zeraR, registraR;
  logic [3:0] chaves;
  logic       fimC, igual, jogada;
  logic [3:0] db_contagem, db_memoria, db_chaves;

  int n_tests = 0;
  int n_fail  = 0;

  int rom_ref [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  exp3_fluxo_dados #(
    .ADDR_W(4),
    .DATA_W(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .zeraC      (zeraC),
    .contaC     (contaC),
    .zeraR      (zeraR),
    .registraR  (registraR),
    .chaves     (chaves),
    .fimC       (fimC),
    .igual      (igual),
    .jogada     (jogada),
    .db_contagem(db_contagem),
    .db_memoria (db_memoria),
    .db_chaves  (db_chaves)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, zc, cc, zr, rr;
    logic [3:0] chv;
    logic [3:0] e_cont, e_mem, e_reg;
    logic       e_ig, e_fim, e_jog;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, zc, cc, zr, rr, input logic [3:0] c);
    reset = r; zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = c;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [3:0] c);
    drive(0, 0, 0, 0, 0, c);
  endtask

  task automatic check_all(input string tag, input int cnt, mem, rg, ig, fim, jog);
    check({tag, ".cont"}, db_contagem, cnt);
    check({tag, ".mem"}, db_memoria, mem);
    check({tag, ".reg"}, db_chaves, rg);
    check({tag, ".igual"}, igual, ig);
    check({tag, ".fimC"}, fimC, fim);
    check({tag, ".jogada"}, jogada, jog);
  endtask

  initial begin
    // rst zc cc zr rr chv | cont mem reg igual fim jog
    vecs[0] = '{1, 0, 0, 0, 0, 4'h0, 4'd0, 4'h1, 4'h0, 0, 0, 0}; // reset
    vecs[1] = '{0, 0, 0, 0, 0, 4'h1, 4'd0, 4'h1, 4'h0, 0, 0, 0}; // s1 <= 1
    vecs[2] = '{0, 0, 0, 0, 0, 4'h1, 4'd0, 4'h1, 4'h0, 0, 0, 1}; // s2 <= 1, pulse
    vecs[3] = '{0, 0, 0, 0, 1, 4'h1, 4'd0, 4'h1, 4'h1, 1, 0, 0}; // load 1, match
    vecs[4] = '{0, 0, 1, 0, 0, 4'h1, 4'd1, 4'h2, 4'h1, 0, 0, 0}; // addr 1
    vecs[5] = '{0, 0, 1, 0, 0, 4'h1, 4'd2, 4'h4, 4'h1, 0, 0, 0}; // addr 2

    idle(4'h0);
    for (int unsigned i = 0; i < 6; i++) begin
      drive(vecs[i].rst, vecs[i].zc, vecs[i].cc, vecs[i].zr, vecs[i].rr, vecs[i].chv);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_cont, vecs[i].e_mem, vecs[i].e_reg,
                vecs[i].e_ig, vecs[i].e_fim, vecs[i].e_jog);
    end

    // Full count from 0 to 15, then wrap.
    drive(0, 1, 0, 0, 0, 4'h1); step();
    check("zeraC.cont", db_contagem, 0);
    for (int unsigned i = 1; i <= 15; i++) begin
      drive(0, 0, 1, 0, 0, 4'h1); step();
      check($sformatf("count%0d.cont", i), db_contagem, i);
      check($sformatf("count%0d.mem", i), db_memoria, rom_ref[i]);
      check($sformatf("count%0d.fimC", i), fimC, (i == 15) ? 1 : 0);
    end
    drive(0, 0, 1, 0, 0, 4'h1); step();
    check("wrap.cont", db_contagem, 0);
    check("wrap.fimC", fimC, 0);
    check("wrap.igual", igual, 1);

    // Simultaneous zeraC + contaC at count 5.
    for (int unsigned i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 4'h1); step();
    end
    check("at5.cont", db_contagem, 5);
    drive(0, 1, 1, 0, 0, 4'h1); step();
    check("zc_cc.cont", db_contagem, 0);

    // Register 8, then simultaneous zeraR + registraR.
    idle(4'h8); step(); step();
    drive(0, 0, 0, 0, 1, 4'h8); step();
    check("reg8.reg", db_chaves, 8);
    check("reg8.igual", igual, 0);
    drive(0, 0, 0, 1, 1, 4'h8); step();
    check("zr_rr.reg", db_chaves, 0);

    // registraR one edge after s1 update loads the old s2 value.
    idle(4'h2); step();
    drive(0, 0, 0, 0, 1, 4'h2); step();
    check("old_s2.reg", db_chaves, 8);

    // Play pulse: clear switches, then 0000 -> 0100.
    idle(4'h0); step(); step(); step();
    check("quiet.jogada", jogada, 0);
    idle(4'h4); step();
    check("pulse_n.jogada", jogada, 0);
    step();
    check("pulse_n1.jogada", jogada, 1);
    step();
    check("pulse_n2.jogada", jogada, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d.jogada", i), jogada, 0);
    end
    idle(4'h2);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check($sformatf("nz2nz%0d.jogada", i), jogada, 0);
    end
    idle(4'h0); step(); step(); step();
    idle(4'h8); step();
    check("repulse_n.jogada", jogada, 0);
    step();
    check("repulse_n1.jogada", jogada, 1);
    step();
    check("repulse_n2.jogada", jogada, 0);

    // Reset mid-operation at count 7, register 8, change in flight.
    drive(0, 1, 0, 0, 1, 4'h8); step();
    for (int unsigned i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0, 0, 4'h8); step();
    end
    check("mid.cont", db_contagem, 7);
    check("mid.reg", db_chaves, 8);
    check("mid.mem", db_memoria, 1);
    idle(4'h0); step(); step(); step();
    idle(4'h4); step();
    drive(1, 0, 1, 0, 1, 4'h0); step();
    check_all("midrst", 0, 1, 0, 0, 0, 0);
    idle(4'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check($sformatf("discard%0d.jogada", i), jogada, 0);
      check($sformatf("discard%0d.reg", i), db_chaves, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp3_fluxo_dados.md
# exp3_fluxo_dados

Datapath for the Experiment 3 memory-check circuit. It holds the address counter, a fixed 16×4 reference memory, the register for the player's switch value (`chaves`), the comparator, and an input synchronizer with a "play made" pulse detector. It sits directly beside the control unit:

- It consumes the control unit's `zeraC`, `contaC`, `zeraR` and `registraR`.
- It produces `fimC` and `igual`, which drive the control unit's transitions.

## Interface

Parameters:
- `ADDR_W`, default 4: counter/address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 4: width of memory words, `chaves` and the register.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high. It clears every flop on the next rising edge.
- `zeraC` in 1: synchronous clear of the address counter.
- `contaC` in 1: increment the address counter.
- `zeraR` in 1: synchronous clear of the switch register.
- `registraR` in 1: load the synchronized `chaves` into the switch register.
- `chaves` in DATA_W: raw, asynchronous player switches.
- `fimC` out 1: high when the counter equals 2^ADDR_W−1.
- `igual` out 1: high when register == memory word at the current address.
- `jogada` out 1: one-cycle pulse when the synchronized `chaves` goes from all-zero to non-zero.
- `db_contagem` out ADDR_W: current counter value.
- `db_memoria` out DATA_W: memory word at the current address.
- `db_chaves` out DATA_W: current register contents.

## Operation

- **Address counter**
  - Priority per edge: `reset`, then `zeraC`, then `contaC`, else hold.
  - Increment wraps from 15 to 0.
  - `fimC` is combinational from the counter value.
- **Memory**
  - Read-only, combinational read addressed by the counter.
  - Contents, addresses 0..15: 1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4 (hex, 4-bit).
- **Switch register**
  - Priority per edge: `reset`, then `zeraR`, then `registraR`, else hold.
  - Loads from the synchronizer output `s2`, never from raw `chaves`.
- **Comparator**
  - `igual` = (`db_chaves` == `db_memoria`), combinational, full DATA_W-bit equality.
- **Synchronizer**
  - Three DATA_W-wide flops in a chain: `s1` ← `chaves`, `s2` ← `s1`, `s2_d` ← `s2`.
- **Play detector**
  - `jogada` = (`s2` ≠ 0) AND (`s2_d` == 0), Moore, taken from flops only.
  - A change from one non-zero value to another non-zero value does not pulse.
  - Holding a non-zero value gives exactly one pulse.
- **Output values after reset:**
  - `db_contagem` = 0, `fimC` = 0.
  - `db_memoria` = 1, `db_chaves` = 0, `igual` = 0.
  - `jogada` = 0.
- **Reset mid-operation:** overrides all control inputs in the same edge and discards any in-flight synchronizer data.

## Timing

- Counter and register update take effect on the edge where the control input is sampled high. `fimC`, `igual` and `db_*` reflect the new value in the following cycle.
- The memory read has zero-cycle latency: `db_memoria` follows `db_contagem` combinationally.
- Switch path, with `chaves` stable before edge n:
  - `s1` updates at edge n, `s2` at edge n+1.
  - `jogada` is high from edge n+1 to edge n+2, exactly one cycle.
  - `registraR` sampled at edge n+2 or later loads the new value; `registraR` at edge n+1 loads the old `s2`.
- Simultaneous `zeraC`+`contaC` clears; simultaneous `zeraR`+`registraR` clears.

## Structure

- A shared package holds:
  - the `ADDR_W`/`DATA_W` defaults;
  - the 16-entry memory contents constant;
  - `FIM_CONTAGEM` = 2^ADDR_W−1.
- One sub-module, `exp3_rom_16x4`: combinational ROM taking an address and returning data, initialised from the package constant.
- The counter, register, comparator, synchronizer and detector stay in the top module.

## Test plan

- **Reset:** assert `reset` for one edge → `db_contagem` = 0, `db_memoria` = 1, `db_chaves` = 0, `igual` = 0, `fimC` = 0, `jogada` = 0.
- **Load and compare:** `chaves` = 0001 held 2 cycles, then `registraR` for one edge → `db_chaves` = 0001, `igual` = 1 at address 0. Then one `contaC` → address 1, `db_memoria` = 2, `igual` = 0.
- **Full count and wrap:** 15 `contaC` edges → `db_contagem` = 15, `fimC` = 1, `db_memoria` = 4. One more → `db_contagem` = 0, `fimC` = 0.
- **Simultaneous controls:** at count 5, assert `zeraC`+`contaC` together → count 0. With register 8, assert `zeraR`+`registraR` together → `db_chaves` = 0.
- **Play pulse:**
  - `chaves` 0000→0100 before edge n → `jogada` = 1 only between edges n+1 and n+2.
  - Holding 0100 gives no further pulse.
  - 0100→0010 gives no pulse.
  - 0010→0000→1000 pulses again.
- **Reset mid-operation:** at count 7 with register = 8 and a `chaves` change in flight, assert `reset` together with `contaC` and `registraR` → count 0, `db_chaves` = 0, no `jogada` pulse afterwards from the discarded value.
